booth_r4_seq_mult: RTL and testbench

BOOTH_R4_SEQ_MULT -- requirements
Module: booth_r4_seq_mult

---
 rtl/booth_r4_pkg.sv | 18 +
 rtl/booth_r4_enc.sv | 21 ++
 rtl/booth_r4_seq_mult.sv | 137 +++++++++++++
 tb/tb_booth_r4_seq_mult.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/booth_r4_pkg.sv
// Shared types for the radix-4 Booth sequential multiplier.
// Build option: define BOOTH_R4_ACC_EN to compile in the accumulate feature.
package booth_r4_pkg;

    // Booth digit selected for one radix-4 group
    typedef enum logic [2:0] {ZERO, PX, P2X, NX, N2X} booth_digit_e;

    // Control FSM states
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    // Guard bits added above the 2*WIDTH product when accumulating
`ifdef BOOTH_R4_ACC_EN
    localparam int RES_GUARD = 8;
`else
    localparam int RES_GUARD = 0;
`endif

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier group {b[2k+1], b[2k], b[2k-1]} to a digit.
module booth_r4_enc
    import booth_r4_pkg::*;
(
    input  logic [2:0]   i_grp,
    output booth_digit_e o_digit
);

    // Pure lookup, no state
    always_comb begin
        o_digit = ZERO;
        case (i_grp)
            3'b001, 3'b010: o_digit = PX;
            3'b011:         o_digit = P2X;
            3'b100:         o_digit = N2X;
            3'b101, 3'b110: o_digit = NX;
            default:        o_digit = ZERO;
        endcase
    end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// Sequential radix-4 Booth multiplier, one digit per cycle, valid/ready on both sides.
// Build option: BOOTH_R4_ACC_EN adds i_acc and widens o_result by 8 guard bits so
// successive products can be summed into the result register.
module booth_r4_seq_mult
    import booth_r4_pkg::*;
#(
    parameter int WIDTH = 18
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_valid,
    output logic                            o_ready,
    input  logic                            i_multa_ns,
    input  logic                            i_multb_ns,
    input  logic [WIDTH-1:0]                i_multa,
    input  logic [WIDTH-1:0]                i_multb,
`ifdef BOOTH_R4_ACC_EN
    input  logic                            i_acc,
`endif
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic [2*WIDTH+RES_GUARD-1:0]    o_result
);

    localparam int PW = 2 * WIDTH;              // product width; all arithmetic is mod 2^PW
    localparam int RW = PW + RES_GUARD;
    localparam int N  = WIDTH / 2 + 1;          // Booth digits for a WIDTH+2 bit operand
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_e          r_state, w_state_nxt;
    logic [PW-1:0]   r_mcand;                   // multiplicand, pre-shifted by 4^k
    logic [WIDTH+2:0] r_mplr;                   // extended multiplier with appended 0 LSB
    logic [PW-1:0]   r_acc;
    logic [CW-1:0]   r_cnt;
    logic [RW-1:0]   r_result;
`ifdef BOOTH_R4_ACC_EN
    logic            r_sgn;
    logic            r_accm;
`endif

    booth_digit_e    w_digit;
    logic [PW-1:0]   w_pp;
    logic [PW-1:0]   w_acc_nxt;
    logic            w_cap;
    logic            w_last;

    assign w_cap    = i_valid && o_ready;
    assign w_last   = (r_state == BUSY) && (r_cnt == CW'(N - 1));
    assign o_result = r_result;

    booth_r4_enc u_enc (
        .i_grp   (r_mplr[2:0]),
        .o_digit (w_digit)
    );

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        o_ready     = 1'b0;
        o_valid     = 1'b0;
        case (r_state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) w_state_nxt = BUSY;
            end
            BUSY: begin
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Partial product for the current digit; negation is two's complement mod 2^PW
    always_comb begin
        w_pp = '0;
        case (w_digit)
            PX:      w_pp = r_mcand;
            P2X:     w_pp = r_mcand << 1;
            NX:      w_pp = -r_mcand;
            N2X:     w_pp = -(r_mcand << 1);
            default: w_pp = '0;
        endcase
    end

    assign w_acc_nxt = r_acc + w_pp;

    // Operand capture, digit iteration and result update on entry to DONE
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mcand  <= '0;
            r_mplr   <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
`ifdef BOOTH_R4_ACC_EN
            r_sgn    <= 1'b0;
            r_accm   <= 1'b0;
`endif
        end else if (w_cap) begin
            r_mcand <= {{WIDTH{i_multa_ns & i_multa[WIDTH-1]}}, i_multa};
            r_mplr  <= {{2{i_multb_ns & i_multb[WIDTH-1]}}, i_multb, 1'b0};
            r_acc   <= '0;
            r_cnt   <= '0;
`ifdef BOOTH_R4_ACC_EN
            r_sgn   <= i_multa_ns | i_multb_ns;
            r_accm  <= i_acc;
`endif
        end else if (r_state == BUSY) begin
            r_acc   <= w_acc_nxt;
            r_mcand <= r_mcand << 2;
            r_mplr  <= r_mplr >> 2;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_cnt <= '0;
`ifdef BOOTH_R4_ACC_EN
                if (r_accm)
                    r_result <= r_result + {{RES_GUARD{r_sgn & w_acc_nxt[PW-1]}}, w_acc_nxt};
                else
                    r_result <= {{RES_GUARD{r_sgn & w_acc_nxt[PW-1]}}, w_acc_nxt};
`else
                r_result <= w_acc_nxt;
`endif
            end
        end
    end

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Self-checking bench for booth_r4_seq_mult (WIDTH=18), directed plus random operations.
module tb_booth_r4_seq_mult;

    localparam int WIDTH = 18;
    localparam int N     = WIDTH / 2 + 1;
    localparam int PW    = 2 * WIDTH;
`ifdef BOOTH_R4_ACC_EN
    localparam int RW    = PW + 8;
`else
    localparam int RW    = PW;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             i_valid;
    logic             o_ready;
    logic             sa_in;
    logic             sb_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             acc_in;
    logic             o_valid;
    logic             i_ready;
    logic [RW-1:0]    o_result;

    int               n_assert = 0;
    int               n_fail   = 0;
    logic [RW-1:0]    model_res;

    always #5 clk = ~clk;

    booth_r4_seq_mult #(.WIDTH(WIDTH)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_multa_ns (sa_in),
        .i_multb_ns (sb_in),
        .i_multa    (a_in),
        .i_multb    (b_in),
`ifdef BOOTH_R4_ACC_EN
        .i_acc      (acc_in),
`endif
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_result   (o_result)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer multiply of the extended operands
    function automatic logic [RW-1:0] ref_result(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                 input logic sa, input logic sb, input logic acc,
                                                 input logic [RW-1:0] prev);
        longint        ea, eb, p, ps;
        logic [PW-1:0] pl;
        logic [RW-1:0] pe;
        ea = sa ? longint'($signed(a)) : longint'(a);
        eb = sb ? longint'($signed(b)) : longint'(b);
        p  = ea * eb;
        pl = p[PW-1:0];
        ps = (sa || sb) ? longint'($signed(pl)) : longint'(pl);
        pe = ps[RW-1:0];
`ifdef BOOTH_R4_ACC_EN
        return acc ? prev + pe : pe;
`else
        return (acc && 1'b0) ? prev : pe;
`endif
    endfunction

    // One full transaction: capture, N busy cycles, hold in DONE, then release
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic sa, input logic sb, input logic acc,
                          input int hold, input string tag);
        logic [RW-1:0] exp;
        logic          early;
        exp     = ref_result(a, b, sa, sb, acc, model_res);
        i_valid = 1'b1;
        a_in    = a;
        b_in    = b;
        sa_in   = sa;
        sb_in   = sb;
        acc_in  = acc;
        chk({tag, ":ready_idle"}, RW'(o_ready), RW'(1));
        step();
        // inputs churn during BUSY and must be ignored
        i_valid = 1'($urandom);
        a_in    = WIDTH'($urandom);
        b_in    = WIDTH'($urandom);
        sa_in   = 1'($urandom);
        sb_in   = 1'($urandom);
        acc_in  = 1'($urandom);
        early   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (o_valid !== 1'b0 || o_ready !== 1'b0 || o_result !== model_res) early = 1'b1;
            step();
        end
        i_valid = 1'b0;
        chk({tag, ":busy_quiet"}, RW'(early), RW'(0));
        chk({tag, ":valid"}, RW'(o_valid), RW'(1));
        chk({tag, ":result"}, o_result, exp);
        for (int h = 0; h < hold; h++) begin
            step();
            chk({tag, ":hold_valid"}, RW'(o_valid), RW'(1));
            chk({tag, ":hold_ready"}, RW'(o_ready), RW'(0));
            chk({tag, ":hold_result"}, o_result, exp);
        end
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
        chk({tag, ":drop_valid"}, RW'(o_valid), RW'(0));
        chk({tag, ":back_ready"}, RW'(o_ready), RW'(1));
        chk({tag, ":idle_result"}, o_result, exp);
        model_res = exp;
    endtask

    initial begin
        rst       = 1'b1;
        i_valid   = 1'b0;
        i_ready   = 1'b0;
        a_in      = '0;
        b_in      = '0;
        sa_in     = 1'b0;
        sb_in     = 1'b0;
        acc_in    = 1'b0;
        model_res = '0;
        step();
        step();
        rst = 1'b0;
        chk("rst_ready", RW'(o_ready), RW'(1));
        chk("rst_valid", RW'(o_valid), RW'(0));
        chk("rst_result", o_result, '0);

        // signed*signed, also pins the valid latency at T+N+1
        run_op(18'h20000, 18'h20000, 1'b1, 1'b1, 1'b0, 0, "ss_min");
        chk("ss_min_const", RW'(o_result[PW-1:0]), RW'(36'h4_0000_0000));

        run_op(18'h3FFFF, 18'h3FFFF, 1'b0, 1'b0, 1'b0, 0, "uu_max");
        chk("uu_max_const", RW'(o_result[PW-1:0]), RW'(36'hF_FFF8_0001));

        run_op(18'h3FFFF, 18'h3FFFF, 1'b1, 1'b0, 1'b0, 0, "su_m1");
        chk("su_m1_const", RW'(o_result[PW-1:0]), RW'(36'hF_FFFC_0001));

        // backpressure for 5 cycles in DONE
        run_op(18'h12345, 18'h2ABCD, 1'b0, 1'b1, 1'b0, 5, "bp");

        // reset in the middle of BUSY
        i_valid = 1'b1;
        a_in    = 18'h1F0F0;
        b_in    = 18'h0AAAA;
        sa_in   = 1'b1;
        sb_in   = 1'b1;
        acc_in  = 1'b0;
        step();
        i_valid = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_valid", RW'(o_valid), RW'(0));
        chk("midrst_result", o_result, '0);
        chk("midrst_ready", RW'(o_ready), RW'(1));
        model_res = '0;
        run_op(18'h00007, 18'h3FFF9, 1'b0, 1'b1, 1'b0, 1, "after_rst");

`ifdef BOOTH_R4_ACC_EN
        run_op(18'd3, 18'd5, 1'b0, 1'b0, 1'b0, 0, "acc_first");
        chk("acc_15", o_result, RW'(15));
        run_op(18'd2, 18'd7, 1'b0, 1'b0, 1'b1, 0, "acc_second");
        chk("acc_29", o_result, RW'(29));
`endif

        // random operands, modes, accumulate bit and backpressure
        for (int r = 0; r < 20; r++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), int'($urandom_range(0, 3)), $sformatf("rnd%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
